// File: rtl/serializer_pkg.sv
// -----------------------------------------------------------------------------
// serializer_pkg
// Shared types and helpers for the parallel-in/serial-out serializer.
//   ser_state_t  : frame sequencing states (IDLE, SHIFT, PARITY, DONE)
//   PAR_MAX_W    : widest word the parity helper accepts
//   even_parity  : returns the bit that makes the total count of ones even
// -----------------------------------------------------------------------------
package serializer_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2,
        DONE   = 2'd3
    } ser_state_t;

    // Words narrower than this are zero-extended before the parity reduction;
    // extra zeros do not change the result.
    localparam int unsigned PAR_MAX_W = 64;

    // Even parity bit: XOR of all data bits, so data plus parity holds an even
    // number of ones.
    function automatic logic even_parity(input logic [PAR_MAX_W-1:0] i_word);
        even_parity = ^i_word;
    endfunction

endpackage : serializer_pkg

// File: rtl/piso_serializer.sv
// -----------------------------------------------------------------------------
// piso_serializer
// Captures a parallel word on a start request and shifts it out one bit per
// clock, optionally followed by an even-parity bit. busy/done let a controller
// sequence the next load of the upstream holding register.
//
// Parameters:
//   WIDTH     : data word width (2 .. PAR_MAX_W)
//   MSB_FIRST : 1 = bit WIDTH-1 leaves first, 0 = bit 0 leaves first
//   PARITY_EN : 1 = append one even-parity bit after the data bits
//
// Ports:
//   clk   in   rising-edge clock
//   rst   in   asynchronous active-high reset; aborts any frame in progress
//   start in   load din and begin a frame (ignored unless idle)
//   din   in   parallel word, sampled only on the accepting edge
//   sout  out  serial data (0 when not transmitting)
//   busy  out  high while data or parity bits are on sout
//   done  out  one-cycle pulse after the last bit of a frame
//
// All outputs are a pure decode of registered state, so they react to rst
// immediately and never depend combinationally on start or din.
// -----------------------------------------------------------------------------
import serializer_pkg::*;

module piso_serializer #(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1,
    parameter int PARITY_EN = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] din,
    output logic             sout,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    ser_state_t             r_state;
    ser_state_t             w_state_next;
    logic [WIDTH-1:0]       r_shreg;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_par;

    logic [WIDTH-1:0]       w_shreg_shifted;
    logic                   w_out_bit;
    logic                   w_last_bit;
    logic [PAR_MAX_W-1:0]   w_din_ext;

    // Zero-extend the input word to the width the parity helper expects.
    always_comb begin
        w_din_ext            = '0;
        w_din_ext[WIDTH-1:0] = din;
    end

    // Shift toward the output end with zero fill, and select the output bit.
    always_comb begin
        if (MSB_FIRST != 0) begin
            w_shreg_shifted = {r_shreg[WIDTH-2:0], 1'b0};
            w_out_bit       = r_shreg[WIDTH-1];
        end else begin
            w_shreg_shifted = {1'b0, r_shreg[WIDTH-1:1]};
            w_out_bit       = r_shreg[0];
        end
    end

    // The counter reaches WIDTH-1 while the last data bit is on sout.
    assign w_last_bit = (r_cnt == LAST_CNT);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode; start only matters in IDLE, so it is never queued.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_next = SHIFT;
                end else begin
                    w_state_next = IDLE;
                end
            end
            SHIFT: begin
                if (w_last_bit) begin
                    w_state_next = (PARITY_EN != 0) ? PARITY : DONE;
                end else begin
                    w_state_next = SHIFT;
                end
            end
            PARITY:  w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Datapath: word, bit counter and parity are captured only on the
    // accepting edge, so later din changes cannot disturb the frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shreg <= '0;
            r_cnt   <= '0;
            r_par   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_shreg <= din;
                        r_cnt   <= '0;
                        r_par   <= even_parity(w_din_ext);
                    end else begin
                        r_shreg <= r_shreg;
                        r_cnt   <= r_cnt;
                        r_par   <= r_par;
                    end
                end
                SHIFT: begin
                    r_shreg <= w_shreg_shifted;
                    // Hold at the final count so narrow counters never wrap.
                    if (w_last_bit) begin
                        r_cnt <= r_cnt;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                    r_par   <= r_par;
                end
                default: begin
                    r_shreg <= r_shreg;
                    r_cnt   <= r_cnt;
                    r_par   <= r_par;
                end
            endcase
        end
    end

    // Moore output decode.
    always_comb begin
        sout = 1'b0;
        busy = 1'b0;
        done = 1'b0;
        case (r_state)
            IDLE: begin
                sout = 1'b0;
                busy = 1'b0;
                done = 1'b0;
            end
            SHIFT: begin
                sout = w_out_bit;
                busy = 1'b1;
            end
            PARITY: begin
                sout = r_par;
                busy = 1'b1;
            end
            DONE: begin
                done = 1'b1;
            end
            default: begin
                sout = 1'b0;
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

endmodule : piso_serializer

// File: tb/tb_piso_serializer.sv
// Self-checking bench for piso_serializer. Two instances: dut_a uses the
// default parameters (MSB first, parity on); dut_b is LSB first without parity.
// Each cycle of a frame has its expected (sout, busy, done) pushed to a
// scoreboard queue when the frame is launched, and popped per cycle.
module tb_piso_serializer;

    logic       clk;
    logic       rst;
    logic       start_a, start_b;
    logic [7:0] din_a, din_b;
    logic       sout_a, busy_a, done_a;
    logic       sout_b, busy_b, done_b;

    int n_checks;
    int n_pass;

    typedef struct {
        logic       s;
        logic       b;
        logic       d;
        logic [1:0] kind;
    } exp_t;

    exp_t sb_q[$];

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1), .PARITY_EN(1)) dut_a (
        .clk   (clk),
        .rst   (rst),
        .start (start_a),
        .din   (din_a),
        .sout  (sout_a),
        .busy  (busy_a),
        .done  (done_a)
    );

    piso_serializer #(.WIDTH(8), .MSB_FIRST(0), .PARITY_EN(0)) dut_b (
        .clk   (clk),
        .rst   (rst),
        .start (start_b),
        .din   (din_b),
        .sout  (sout_b),
        .busy  (busy_b),
        .done  (done_b)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog against a hung run.
    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // Single comparison point for the whole bench.
    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (obs === exp) begin
            n_pass = n_pass + 1;
        end else begin
            $display("FAIL %s: observed=%0h required=%0h", tag, obs, exp);
        end
    endtask

    function automatic string kind_name(input logic [1:0] k);
        case (k)
            2'd0:    return "data";
            2'd1:    return "parity";
            2'd2:    return "done";
            default: return "idle";
        endcase
    endfunction

    task automatic check_outs(input int sel, input string tag, input logic s, input logic b, input logic d);
        if (sel == 0) begin
            check_val({tag, ".a.sout"}, {31'd0, sout_a}, {31'd0, s});
            check_val({tag, ".a.busy"}, {31'd0, busy_a}, {31'd0, b});
            check_val({tag, ".a.done"}, {31'd0, done_a}, {31'd0, d});
        end else begin
            check_val({tag, ".b.sout"}, {31'd0, sout_b}, {31'd0, s});
            check_val({tag, ".b.busy"}, {31'd0, busy_b}, {31'd0, b});
            check_val({tag, ".b.done"}, {31'd0, done_b}, {31'd0, d});
        end
    endtask

    // Launch one frame from a negedge in an idle cycle and check every cycle
    // through the following idle cycle. hold keeps start high throughout;
    // iso pulses start with a new din in the middle of SHIFT.
    task automatic frame(input int sel, input logic [7:0] d, input bit hold, input bit iso);
        exp_t e;
        int   ones;
        int   n;
        bit   msb;
        bit   pen;
        msb  = (sel == 0);
        pen  = (sel == 0);
        ones = 0;
        for (int k = 0; k < 8; k++) begin
            e.s    = msb ? d[7-k] : d[k];
            e.b    = 1'b1;
            e.d    = 1'b0;
            e.kind = 2'd0;
            sb_q.push_back(e);
            if (d[k]) ones = ones + 1;
        end
        if (pen) begin
            e.s = ((ones % 2) == 1) ? 1'b1 : 1'b0;
            e.b = 1'b1; e.d = 1'b0; e.kind = 2'd1;
            sb_q.push_back(e);
        end
        e.s = 1'b0; e.b = 1'b0; e.d = 1'b1; e.kind = 2'd2;
        sb_q.push_back(e);
        e.s = 1'b0; e.b = 1'b0; e.d = 1'b0; e.kind = 2'd3;
        sb_q.push_back(e);
        if (iso) begin
            sb_q.push_back(e);
            sb_q.push_back(e);
        end
        if (sel == 0) begin
            din_a = d; start_a = 1'b1;
        end else begin
            din_b = d; start_b = 1'b1;
        end
        @(negedge clk);
        if (!hold) begin
            start_a = 1'b0;
            start_b = 1'b0;
        end
        n = 0;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_outs(sel, $sformatf("%s[%0d]", kind_name(e.kind), n), e.s, e.b, e.d);
            if (iso && n == 2) begin
                din_a = 8'h00; start_a = 1'b1;
            end
            if (iso && n == 3) begin
                start_a = 1'b0;
            end
            n = n + 1;
            if (sb_q.size() > 0) @(negedge clk);
        end
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst      = 1'b1;
        start_a  = 1'b0;
        start_b  = 1'b0;
        din_a    = 8'h00;
        din_b    = 8'h00;

        // Reset state.
        @(negedge clk);
        check_outs(0, "reset", 1'b0, 1'b0, 1'b0);
        check_outs(1, "reset", 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_outs(0, "post_reset_idle", 1'b0, 1'b0, 1'b0);
        end

        // Basic MSB-first frame and parity variations.
        frame(0, 8'b11001111, 1'b0, 1'b0);
        frame(0, 8'b10001001, 1'b0, 1'b0);
        frame(0, 8'b00000001, 1'b0, 1'b0);
        frame(0, 8'b11111111, 1'b0, 1'b0);

        // Input isolation: din change and start pulse during SHIFT are ignored.
        frame(0, 8'b11111111, 1'b0, 1'b1);

        // Abort: reset between edges while the 4th data bit is on sout.
        din_a   = 8'hB7;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check_outs(0, "abort_bit3", 1'b1, 1'b1, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check_outs(0, "abort_async", 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_outs(0, "abort_idle", 1'b0, 1'b0, 1'b0);
        frame(0, 8'b00000001, 1'b0, 1'b0);

        // LSB-first, no parity.
        frame(1, 8'b11001111, 1'b0, 1'b0);
        frame(1, 8'b10000010, 1'b0, 1'b0);

        // start held high: frames back to back with DONE + IDLE between.
        frame(0, 8'h3C, 1'b1, 1'b0);
        frame(0, 8'h5A, 1'b0, 1'b0);
        @(negedge clk);
        check_outs(0, "after_hold_idle", 1'b0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_piso_serializer
